row_pingpong_reader: RTL and testbench
======================================

// Module: row_pingpong_reader
// PURPOSE
//  Consumes the 16-bit word stream, addresses and write-enable produced by set_data,
//  one ROW_LEN-word row per address cycle. Captures each row into one bank of a
//  two-bank (ping-pong) buffer while the other bank streams out over a valid/ready
//  interface toward the readout FIFO / TCP sender, with a last marker and drop stats.
// PARAMETERS
//  ROW_LEN    48  words per row; writes at MEM_ADDR >= ROW_LEN are ignored
//  AW          6  address width of MEM_ADDR and of each bank (depth 2**AW >= ROW_LEN)
//  CNT_W      16  width of the saturating statistics counters
// PORTS
//  CLK             in   1      system clock
//  RST             in   1      synchronous reset, active-high
//  FIRST_ROW_FLAG  in   1      from set_data; first high after reset arms capture
//  DATA_IN         in   16     row word (set_data DATA_OUT)
//  MEM_ADDR        in   AW     word index within row (set_data MEM_ADDR)
//  MEM_WREN        in   1      write enable (set_data MEM_WREN)
//  OUT_DATA        out  16     streamed row word
//  OUT_VALID       out  1      OUT_DATA valid
//  OUT_READY       in   1      downstream accepts word when OUT_VALID & OUT_READY
//  OUT_LAST        out  1      high with word ROW_LEN-1 of a row
//  ARMED           out  1      capture armed
//  DROP_CNT        out  CNT_W  rows discarded because no bank was free (saturating)
//  TRUNC_CNT       out  CNT_W  rows abandoned by early MEM_ADDR==0 (saturating)
// BEHAVIOUR
//  Reset (any cycle, incl. mid-row/mid-stream): OUT_VALID=0, OUT_LAST=0, OUT_DATA=0,
//   ARMED=0, both bank-full flags=0, write bank=0, read bank=0, counters=0. RAM not cleared.
//  Arming: ARMED sets the cycle after FIRST_ROW_FLAG is sampled high; stays set until RST.
//   Capture starts at the first MEM_WREN & MEM_ADDR==0 with ARMED=1; earlier words ignored.
//  Write side, FSM W_WAIT -> W_FILL -> W_WAIT:
//   - W_WAIT: on MEM_WREN & MEM_ADDR==0: if write bank not full, store word 0, go W_FILL;
//     else row dropped: DROP_CNT+1, stay W_WAIT, no RAM write.
//   - W_FILL: each MEM_WREN with MEM_ADDR<ROW_LEN writes bank[MEM_ADDR]=DATA_IN.
//     Write at MEM_ADDR==ROW_LEN-1: bank-full flag set next cycle, write bank toggles, W_WAIT.
//   - MEM_ADDR==0 in W_FILL (early restart): TRUNC_CNT+1, word 0 rewritten into same bank,
//     stay W_FILL; partial row never streamed.
//   - MEM_WREN=0: no write, state held.
//  Read side, FSM R_IDLE -> R_FETCH -> R_STREAM -> R_IDLE:
//   - R_IDLE: read bank full -> R_FETCH (1-cycle RAM read latency).
//   - First OUT_VALID exactly 2 cycles after bank-full flag is visible.
//   - R_STREAM: OUT_DATA/OUT_LAST held stable while OUT_VALID & !OUT_READY; on accept,
//     next word presented following cycle (prefetch), sustaining 1 word/cycle at READY=1.
//   - Accept of word ROW_LEN-1 (OUT_LAST=1): clear that bank-full flag, toggle read bank,
//     R_IDLE; OUT_VALID low for >=1 cycle between rows.
//   - Words delivered in address order 0..ROW_LEN-1, never reordered or repeated.
//  Simultaneous events: bank-full set (write side) and clear (read side) on different
//   banks in the same cycle both take effect. Write never targets the bank being read:
//   write bank is full until read clears it, so row goes to drop path.
//  Counters saturate at 2**CNT_W-1, no wrap.
// TESTING
//  1 RST, FIRST_ROW_FLAG pulse, one row DATA_IN=0x1000+addr, READY=1 -> 48 words
//    0x1000..0x102F back-to-back, OUT_LAST only on 0x102F, first VALID 2 cycles after full.
//  2 Words before FIRST_ROW_FLAG and arming -> no OUT_VALID, DROP_CNT=TRUNC_CNT=0.
//  3 Three rows back-to-back, OUT_READY=0 -> rows 1,2 fill banks, row 3 DROP_CNT=1;
//    release READY -> rows 1 then 2 streamed intact.
//  4 Row restarts MEM_ADDR=0 at addr 20, then full row 0x2000+addr -> TRUNC_CNT=1,
//    output only 0x2000..0x202F.
//  5 OUT_READY toggled pseudo-randomly -> OUT_DATA stable while stalled, all 48 words, no dups.
//  6 RST asserted mid-stream at word 10 -> next cycle OUT_VALID=0, counters 0, ARMED=0.

Source files
------------

// File: rtl/row_pingpong_reader.sv
// row_pingpong_reader
//   Captures ROW_LEN-word rows from the set_data word stream into one bank of a
//   two-bank ping-pong buffer while the other bank streams out over valid/ready.
//   Rows that arrive while no bank is free are dropped and counted; rows that
//   restart early (MEM_ADDR==0 mid-row) are counted as truncated and refilled.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   FIRST_ROW_FLAG  first high after reset arms capture
//   DATA_IN         row word
//   MEM_ADDR        word index within the row
//   MEM_WREN        write enable for DATA_IN/MEM_ADDR
//   OUT_DATA        streamed row word
//   OUT_VALID       OUT_DATA valid
//   OUT_READY       downstream accepts the word when OUT_VALID & OUT_READY
//   OUT_LAST        marks word ROW_LEN-1 of a row
//   ARMED           capture armed
//   DROP_CNT        rows discarded because no bank was free (saturating)
//   TRUNC_CNT       rows abandoned by an early MEM_ADDR==0 (saturating)

module row_pingpong_reader #(
    parameter int unsigned ROW_LEN = 48,
    parameter int unsigned AW      = 6,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FIRST_ROW_FLAG,
    input  logic [15:0]      DATA_IN,
    input  logic [AW-1:0]    MEM_ADDR,
    input  logic             MEM_WREN,
    output logic [15:0]      OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_LAST,
    output logic             ARMED,
    output logic [CNT_W-1:0] DROP_CNT,
    output logic [CNT_W-1:0] TRUNC_CNT
);

    localparam int unsigned   Depth     = 2 ** (AW + 1);
    localparam logic [AW-1:0] LastAddr  = AW'(ROW_LEN - 1);
    localparam logic [AW:0]   RowLenExt = (AW + 1)'(ROW_LEN);

    typedef enum logic {
        WWait,
        WFill
    } wr_state_e;

    typedef enum logic [1:0] {
        RIdle,
        RFetch,
        RStream
    } rd_state_e;

    // Both banks share one array; the bank select is the address MSB.
    logic [15:0] mem [Depth];

    wr_state_e      wr_state_q, wr_state_d;
    rd_state_e      rd_state_q, rd_state_d;
    logic           wbank_q, wbank_d;
    logic           rbank_q, rbank_d;
    logic [1:0]     full_q, full_d;
    logic [AW-1:0]  rd_addr_q, rd_addr_d;
    logic [15:0]    out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic           armed_q, armed_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] trunc_cnt_q, trunc_cnt_d;

    logic mem_we;
    logic addr_zero;
    logic addr_in_range;
    logic accept;
    logic load_word;

    assign addr_zero     = (MEM_ADDR == '0);
    assign addr_in_range = ({1'b0, MEM_ADDR} < RowLenExt);
    assign accept        = out_valid_q & OUT_READY;

    always_comb begin
        wr_state_d  = wr_state_q;
        rd_state_d  = rd_state_q;
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        full_d      = full_q;
        rd_addr_d   = rd_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        armed_d     = armed_q | FIRST_ROW_FLAG;
        drop_cnt_d  = drop_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        mem_we      = 1'b0;
        load_word   = 1'b0;

        // Write side: nothing is captured until armed.
        unique case (wr_state_q)
            WWait: begin
                if (armed_q && MEM_WREN && addr_zero) begin
                    if (!full_q[wbank_q]) begin
                        mem_we     = 1'b1;
                        wr_state_d = WFill;
                    end else if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    end
                end
            end
            WFill: begin
                if (MEM_WREN && addr_in_range) begin
                    mem_we = 1'b1;
                    if (addr_zero) begin
                        // Early restart: the partial row is overwritten in place.
                        if (trunc_cnt_q != '1) begin
                            trunc_cnt_d = trunc_cnt_q + CNT_W'(1);
                        end
                    end else if (MEM_ADDR == LastAddr) begin
                        full_d[wbank_q] = 1'b1;
                        wbank_d         = ~wbank_q;
                        wr_state_d      = WWait;
                    end
                end
            end
            default: wr_state_d = WWait;
        endcase

        // Read side: out_data_q doubles as the RAM read register, so a word is
        // fetched into it on entry (RFetch) and on every accept (prefetch).
        unique case (rd_state_q)
            RIdle: begin
                if (full_q[rbank_q]) begin
                    rd_addr_d  = '0;
                    rd_state_d = RFetch;
                end
            end
            RFetch: begin
                load_word  = 1'b1;
                rd_state_d = RStream;
            end
            RStream: begin
                if (accept) begin
                    if (out_last_q) begin
                        // The write side can only set the other bank this cycle.
                        full_d[rbank_q] = 1'b0;
                        rbank_d         = ~rbank_q;
                        out_valid_d     = 1'b0;
                        out_last_d      = 1'b0;
                        rd_state_d      = RIdle;
                    end else begin
                        load_word = 1'b1;
                    end
                end
            end
            default: rd_state_d = RIdle;
        endcase

        if (load_word) begin
            out_data_d  = mem[{rbank_q, rd_addr_q}];
            out_valid_d = 1'b1;
            out_last_d  = (rd_addr_q == LastAddr);
            rd_addr_d   = rd_addr_q + AW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_state_q  <= WWait;
            rd_state_q  <= RIdle;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            full_q      <= 2'b00;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            armed_q     <= 1'b0;
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            full_q      <= full_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            armed_q     <= armed_d;
            drop_cnt_q  <= drop_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    // Buffer RAM is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[{wbank_q, MEM_ADDR}] <= DATA_IN;
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_LAST  = out_last_q;
    assign ARMED     = armed_q;
    assign DROP_CNT  = drop_cnt_q;
    assign TRUNC_CNT = trunc_cnt_q;

endmodule

// File: tb/tb_row_pingpong_reader.sv
module tb_row_pingpong_reader;

    localparam int RL = 48;
    localparam int AW = 6;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          RST = 1'b0;
    logic          FIRST_ROW_FLAG = 1'b0;
    logic [15:0]   DATA_IN = '0;
    logic [AW-1:0] MEM_ADDR = '0;
    logic          MEM_WREN = 1'b0;
    logic [15:0]   OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic          OUT_LAST;
    logic          ARMED;
    logic [CW-1:0] DROP_CNT;
    logic [CW-1:0] TRUNC_CNT;

    always #5 clk = ~clk;

    row_pingpong_reader #(
        .ROW_LEN(RL),
        .AW     (AW),
        .CNT_W  (CW)
    ) dut (
        .CLK           (clk),
        .RST           (RST),
        .FIRST_ROW_FLAG(FIRST_ROW_FLAG),
        .DATA_IN       (DATA_IN),
        .MEM_ADDR      (MEM_ADDR),
        .MEM_WREN      (MEM_WREN),
        .OUT_DATA      (OUT_DATA),
        .OUT_VALID     (OUT_VALID),
        .OUT_READY     (OUT_READY),
        .OUT_LAST      (OUT_LAST),
        .ARMED         (ARMED),
        .DROP_CNT      (DROP_CNT),
        .TRUNC_CNT     (TRUNC_CNT)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: rows are tracked as whole objects, not as bank state.
    logic [16:0] exp_q[$];       // {last, data} in expected delivery order
    logic [15:0] cur_row[RL];
    logic [15:0] row_buf[RL];
    bit          armed_m;
    bit          cap_m;
    int          rows_held;      // rows captured and not yet fully delivered
    int          cap_rows_m;
    int          drop_m;
    int          trunc_m;
    int          acc_cnt;

    bit          mon_en = 1'b0;
    int          ready_mode = 0;  // 0: low, 1: high, 2: random

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       OUT_READY = 1'b0;
            1:       OUT_READY = 1'b1;
            default: OUT_READY = 1'($urandom_range(0, 1));
        endcase
    end

    // Output scoreboard.
    bit          stall_p = 1'b0;
    bit          gap_p = 1'b0;
    logic [15:0] pd;
    logic        pl;
    logic [16:0] e;

    always @(negedge clk) begin
        if (!mon_en) begin
            stall_p = 1'b0;
            gap_p   = 1'b0;
        end else begin
            if (gap_p) begin
                total++;
                if (OUT_VALID !== 1'b0) begin
                    bad++;
                    $display("FAIL row_gap: OUT_VALID=%b required 0 after last", OUT_VALID);
                end
                gap_p = 1'b0;
            end
            if (stall_p) begin
                total++;
                if (OUT_VALID !== 1'b1 || OUT_DATA !== pd || OUT_LAST !== pl) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                             OUT_VALID, OUT_DATA, OUT_LAST, pd, pl);
                end
            end
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word: got d=%h l=%b required no word",
                             OUT_DATA, OUT_LAST);
                end else begin
                    e = exp_q.pop_front();
                    if ({OUT_LAST, OUT_DATA} !== e) begin
                        bad++;
                        $display("FAIL word: got l=%b d=%h required l=%b d=%h",
                                 OUT_LAST, OUT_DATA, e[16], e[15:0]);
                    end
                    if (e[16]) begin
                        rows_held--;
                        gap_p = 1'b1;
                    end
                end
                acc_cnt++;
                stall_p = 1'b0;
            end else if (OUT_VALID === 1'b1) begin
                stall_p = 1'b1;
                pd      = OUT_DATA;
                pl      = OUT_LAST;
            end else begin
                stall_p = 1'b0;
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        armed_m    = 1'b0;
        cap_m      = 1'b0;
        rows_held  = 0;
        cap_rows_m = 0;
        drop_m     = 0;
        trunc_m    = 0;
        acc_cnt    = 0;
    endtask

    task automatic drive_word(input logic [AW-1:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        MEM_WREN = 1'b1;
        MEM_ADDR = a;
        DATA_IN  = d;
        if (armed_m) begin
            if (!cap_m) begin
                if (a == 0) begin
                    if (rows_held >= 2) begin
                        drop_m++;
                    end else begin
                        cap_m      = 1'b1;
                        cur_row[0] = d;
                    end
                end
            end else if (int'(a) < RL) begin
                if (a == 0) trunc_m++;
                cur_row[a] = d;
                if (int'(a) == RL - 1) begin
                    for (int i = 0; i < RL; i++) exp_q.push_back({(i == RL - 1), cur_row[i]});
                    rows_held++;
                    cap_rows_m++;
                    cap_m = 1'b0;
                end
            end
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        MEM_WREN       = 1'b0;
        FIRST_ROW_FLAG = 1'b0;
    endtask

    task automatic arm();
        @(posedge clk);
        #1;
        MEM_WREN       = 1'b0;
        FIRST_ROW_FLAG = 1'b1;
        armed_m        = 1'b1;
        idle();
    endtask

    // Sends row_buf, optionally preceded by an aborted partial row of restart_at words.
    task automatic send_row(input int restart_at);
        for (int a = 0; a < restart_at; a++) drive_word(AW'(a), 16'h3000 + 16'(a));
        for (int a = 0; a < RL; a++) drive_word(AW'(a), row_buf[a]);
    endtask

    task automatic fill_random();
        for (int a = 0; a < RL; a++) row_buf[a] = 16'($urandom);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        RST            = 1'b1;
        MEM_WREN       = 1'b0;
        FIRST_ROW_FLAG = 1'b0;
        @(posedge clk);
        #1;
        RST = 1'b0;
        model_reset();
        mon_en = 1'b1;
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        while ((exp_q.size() != 0 || rows_held != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        ok = (exp_q.size() == 0 && rows_held == 0);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (OUT_VALID !== 1'b0 || OUT_LAST !== 1'b0 || OUT_DATA !== 16'h0) begin
            bad++;
            $display("FAIL reset_out: got v=%b l=%b d=%h required 0 0 0000",
                     OUT_VALID, OUT_LAST, OUT_DATA);
        end
        total++;
        if (ARMED !== 1'b0 || DROP_CNT !== '0 || TRUNC_CNT !== '0) begin
            bad++;
            $display("FAIL reset_state: got armed=%b drop=%0d trunc=%0d required 0 0 0",
                     ARMED, DROP_CNT, TRUNC_CNT);
        end
        RST = 1'b0;
        model_reset();
        mon_en = 1'b1;
    endtask

    task automatic test_unarmed();
        ready_mode = 1;
        do_reset();
        fill_random();
        send_row(0);
        drive_word(AW'(0), 16'hbeef);
        idle();
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (OUT_VALID !== 1'b0 || ARMED !== 1'b0) begin
            bad++;
            $display("FAIL unarmed_out: got v=%b armed=%b required 0 0", OUT_VALID, ARMED);
        end
        total++;
        if (DROP_CNT !== CW'(drop_m) || TRUNC_CNT !== CW'(trunc_m)) begin
            bad++;
            $display("FAIL unarmed_cnt: got drop=%0d trunc=%0d required %0d %0d",
                     DROP_CNT, TRUNC_CNT, drop_m, trunc_m);
        end
    endtask

    task automatic test_single_row();
        bit ok;
        ready_mode = 1;
        do_reset();
        arm();
        total++;
        if (ARMED !== 1'b1) begin
            bad++;
            $display("FAIL armed: got %b required 1", ARMED);
        end
        for (int a = 0; a < RL; a++) row_buf[a] = 16'h1000 + 16'(a);
        send_row(0);
        idle();                 // edge that captures the last word has passed
        @(posedge clk);
        #1;
        total++;
        if (OUT_VALID !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: got v=%b required 0", OUT_VALID);
        end
        @(posedge clk);
        #1;
        total++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'h1000 || OUT_LAST !== 1'b0) begin
            bad++;
            $display("FAIL latency_first: got v=%b d=%h l=%b required 1 1000 0",
                     OUT_VALID, OUT_DATA, OUT_LAST);
        end
        wait_drain(ok);
        total++;
        if (!ok || acc_cnt != RL) begin
            bad++;
            $display("FAIL single_row_drain: got words=%0d left=%0d required %0d 0",
                     acc_cnt, exp_q.size(), RL);
        end
    endtask

    task automatic test_drop();
        bit ok;
        ready_mode = 0;
        do_reset();
        arm();
        for (int r = 0; r < 3; r++) begin
            fill_random();
            send_row(0);
        end
        idle();
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (DROP_CNT !== CW'(drop_m) || drop_m != 1) begin
            bad++;
            $display("FAIL drop_cnt: got %0d required %0d", DROP_CNT, drop_m);
        end
        total++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_q[0][15:0]) begin
            bad++;
            $display("FAIL drop_stalled: got v=%b d=%h required 1 %h",
                     OUT_VALID, OUT_DATA, exp_q[0][15:0]);
        end
        ready_mode = 1;
        wait_drain(ok);
        total++;
        if (!ok || acc_cnt != 2 * RL) begin
            bad++;
            $display("FAIL drop_drain: got words=%0d required %0d", acc_cnt, 2 * RL);
        end
    endtask

    task automatic test_trunc();
        bit ok;
        ready_mode = 1;
        do_reset();
        arm();
        for (int a = 0; a < RL; a++) row_buf[a] = 16'h2000 + 16'(a);
        send_row(20);
        idle();
        wait_drain(ok);
        total++;
        if (TRUNC_CNT !== CW'(trunc_m) || trunc_m != 1 || DROP_CNT !== '0) begin
            bad++;
            $display("FAIL trunc_cnt: got trunc=%0d drop=%0d required %0d 0",
                     TRUNC_CNT, DROP_CNT, trunc_m);
        end
        total++;
        if (!ok || acc_cnt != RL) begin
            bad++;
            $display("FAIL trunc_drain: got words=%0d required %0d", acc_cnt, RL);
        end
    endtask

    task automatic test_random_ready();
        bit ok;
        ready_mode = 2;
        do_reset();
        arm();
        for (int r = 0; r < 4; r++) begin
            fill_random();
            send_row(0);
            repeat ($urandom_range(0, 3)) idle();
        end
        idle();
        wait_drain(ok);
        total++;
        if (!ok || acc_cnt != RL * cap_rows_m) begin
            bad++;
            $display("FAIL random_drain: got words=%0d required %0d", acc_cnt, RL * cap_rows_m);
        end
        total++;
        if (DROP_CNT !== CW'(drop_m)) begin
            bad++;
            $display("FAIL random_drop: got %0d required %0d", DROP_CNT, drop_m);
        end
    endtask

    task automatic test_reset_midstream();
        int n = 0;
        ready_mode = 1;
        do_reset();
        arm();
        fill_random();
        send_row(5);
        idle();
        while (acc_cnt < 10 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (OUT_VALID !== 1'b1 || TRUNC_CNT !== CW'(trunc_m) || acc_cnt != 10) begin
            bad++;
            $display("FAIL midstream_pre: got v=%b trunc=%0d words=%0d required 1 %0d 10",
                     OUT_VALID, TRUNC_CNT, acc_cnt, trunc_m);
        end
        mon_en = 1'b0;
        RST    = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (OUT_VALID !== 1'b0 || OUT_LAST !== 1'b0 || OUT_DATA !== 16'h0) begin
            bad++;
            $display("FAIL midstream_out: got v=%b l=%b d=%h required 0 0 0000",
                     OUT_VALID, OUT_LAST, OUT_DATA);
        end
        total++;
        if (ARMED !== 1'b0 || DROP_CNT !== '0 || TRUNC_CNT !== '0) begin
            bad++;
            $display("FAIL midstream_state: got armed=%b drop=%0d trunc=%0d required 0 0 0",
                     ARMED, DROP_CNT, TRUNC_CNT);
        end
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_unarmed();
        test_single_row();
        test_drop();
        test_trunc();
        test_random_ready();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
